// File: rtl/stoch_signed_decode.sv
// Signed stochastic bitstream decoder: counts (a_p - a_m) over 2^WINDOW_BITS enabled
// cycles and presents each window result on a valid/ready output with sticky overrun.
// Optional STOCH_DECODE_SAT_EN: saturate a +2^W result to 2^W-1 instead of wrapping.
module stoch_signed_decode #(
    parameter int unsigned WINDOW_BITS = 8
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          a_p,
    input  logic                          a_m,
    output logic signed [WINDOW_BITS:0]   y,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic                          overrun
);

    localparam int unsigned AW = WINDOW_BITS + 2;

    localparam logic signed [AW-1:0]     ACC_ONE   = 1;
    localparam logic signed [AW-1:0]     ACC_M_ONE = -1;
    localparam logic [WINDOW_BITS-1:0]   CNT_ONE   = 1;
    localparam logic [WINDOW_BITS-1:0]   CNT_MAX   = '1;
`ifdef STOCH_DECODE_SAT_EN
    localparam logic signed [AW-1:0]     FULL_POS  = ACC_ONE <<< WINDOW_BITS;
    localparam logic signed [WINDOW_BITS:0] Y_MAX  = {1'b0, {WINDOW_BITS{1'b1}}};
`endif

    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        delta;
    logic signed [AW-1:0]        sum;
    logic [WINDOW_BITS-1:0]      cnt;
    logic                        last;
    logic signed [WINDOW_BITS:0] y_next;

    always_comb begin
        delta = '0;
        if (a_p && !a_m) begin
            delta = ACC_ONE;
        end else if (a_m && !a_p) begin
            delta = ACC_M_ONE;
        end
        sum  = acc + delta;
        last = en && (cnt == CNT_MAX);
`ifdef STOCH_DECODE_SAT_EN
        // Only +2^W overflows y; -2^W is representable as-is.
        if (sum == FULL_POS) begin
            y_next = Y_MAX;
        end else begin
            y_next = sum[WINDOW_BITS:0];
        end
`else
        y_next = sum[WINDOW_BITS:0];
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc     <= '0;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            // y deliberately keeps its last value across a clear.
            acc     <= '0;
            cnt     <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (en) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_ONE;
                end
            end
            if (last) begin
                y       <= y_next;
                y_valid <= 1'b1;
                if (y_valid && !y_ready) begin
                    overrun <= 1'b1;
                end
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Self-checking bench for stoch_signed_decode (WINDOW_BITS=4): table-driven windows,
// handshake/clear/reset sequences and randomized traffic against an integer model.
module tb_stoch_signed_decode;

    localparam int W = 4;
    localparam int N = 16;
`ifdef STOCH_DECODE_SAT_EN
    localparam int FULL_SCALE = 15;
`else
    localparam int FULL_SCALE = -16;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic a_p = 1'b0;
    logic a_m = 1'b0;
    logic y_ready = 1'b0;
    logic signed [W:0] y;
    logic y_valid;
    logic overrun;

    stoch_signed_decode #(.WINDOW_BITS(W)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .en      (en),
        .clear   (clear),
        .a_p     (a_p),
        .a_m     (a_m),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .overrun (overrun)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: plain integer sum and sample count per window.
    int m_sum;
    int m_n;
    int m_y;
    int m_valid;
    int m_ovr;

    typedef struct {
        int np;
        int nm;
        int nboth;
        int exp_y;
    } vec_t;

    vec_t tbl[9];

    function automatic int fmt(int s);
        logic signed [W:0] r;
`ifdef STOCH_DECODE_SAT_EN
        if (s > N - 1) s = N - 1;
`endif
        r = s[W:0];
        return int'(r);
    endfunction

    task automatic model_reset();
        m_sum = 0; m_n = 0; m_y = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input logic e, input logic c, input logic p, input logic m,
                              input logic r);
        int done;
        done = 0;
        if (c) begin
            m_sum = 0; m_n = 0; m_valid = 0; m_ovr = 0;
        end else begin
            if (e) begin
                m_sum = m_sum + int'(p) - int'(m);
                m_n = m_n + 1;
                if (m_n == N) begin
                    done = 1;
                    m_y = fmt(m_sum);
                    m_sum = 0;
                    m_n = 0;
                end
            end
            if (done != 0) begin
                if (m_valid != 0 && !r) m_ovr = 1;
                m_valid = 1;
            end else if (m_valid != 0 && r) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic p, input logic m,
                        input logic r);
        en = e; clear = c; a_p = p; a_m = m; y_ready = r;
        @(posedge CLK);
        model_edge(e, c, p, m, r);
        #1;
        check("y", int'(y), m_y);
        check("y_valid", int'(y_valid), m_valid);
        check("overrun", int'(overrun), m_ovr);
    endtask

    task automatic run_window(input int np, input int nm, input int nb, input logic r_all,
                              input logic r_last);
        logic p;
        logic m;
        for (int i = 0; i < N; i++) begin
            p = (i < nb) || (i >= nb && i < nb + np);
            m = (i < nb) || (i >= nb + np && i < nb + np + nm);
            step(1'b1, 1'b0, p, m, (i == N - 1) ? r_last : r_all);
        end
    endtask

    initial begin
        tbl[0] = '{np: 0,  nm: 0,  nboth: 0,  exp_y: 0};
        tbl[1] = '{np: 12, nm: 4,  nboth: 0,  exp_y: 8};
        tbl[2] = '{np: 4,  nm: 12, nboth: 0,  exp_y: -8};
        tbl[3] = '{np: 16, nm: 0,  nboth: 0,  exp_y: FULL_SCALE};
        tbl[4] = '{np: 0,  nm: 16, nboth: 0,  exp_y: -16};
        tbl[5] = '{np: 0,  nm: 0,  nboth: 16, exp_y: 0};
        tbl[6] = '{np: 3,  nm: 5,  nboth: 8,  exp_y: -2};
        tbl[7] = '{np: 15, nm: 0,  nboth: 1,  exp_y: 15};
        tbl[8] = '{np: 15, nm: 1,  nboth: 0,  exp_y: 14};

        model_reset();
        #12;
        check("rst_y", int'(y), 0);
        check("rst_valid", int'(y_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        nRST = 1'b1;

        // Table-driven windows, consumer always ready.
        for (int k = 0; k < 9; k++) begin
            run_window(tbl[k].np, tbl[k].nm, tbl[k].nboth, 1'b1, 1'b1);
            check($sformatf("tbl%0d_y", k), int'(y), tbl[k].exp_y);
            check($sformatf("tbl%0d_valid", k), int'(y_valid), 1);
        end

        // Enable gating: 16 enabled cycles out of 32 give exactly one result.
        begin
            int results;
            results = 0;
            for (int i = 0; i < 32; i++) begin
                step((i % 2) == 0, 1'b0, 1'b1, 1'b0, 1'b1);
                if (y_valid) results++;
            end
            check("gate_count", results, 1);
            check("gate_y", int'(y), FULL_SCALE);
        end

        // Overrun: two windows unconsumed, then accept on the completion edge.
        run_window(3, 0, 0, 1'b0, 1'b0);
        check("hs1_y", int'(y), 3);
        check("hs1_overrun", int'(overrun), 0);
        run_window(5, 0, 0, 1'b0, 1'b0);
        check("hs2_y", int'(y), 5);
        check("hs2_overrun", int'(overrun), 1);
        run_window(2, 0, 0, 1'b0, 1'b1);
        check("hs3_y", int'(y), 2);
        check("hs3_valid", int'(y_valid), 1);
        check("hs3_overrun", int'(overrun), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_valid", int'(y_valid), 0);
        check("clr_overrun", int'(overrun), 0);
        check("clr_y_hold", int'(y), 2);

        // Mid-window clear discards the partial window and the clear-cycle sample.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        run_window(4, 0, 0, 1'b1, 1'b1);
        check("midclr_y", int'(y), 4);

        // Mid-window asynchronous reset.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        check("arst_y", int'(y), 0);
        check("arst_valid", int'(y_valid), 0);
        check("arst_overrun", int'(overrun), 0);
        @(negedge CLK);
        nRST = 1'b1;
        run_window(6, 0, 0, 1'b1, 1'b1);
        check("midrst_y", int'(y), 6);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 3,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
